// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host link to the FPGA register file.
package spi_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned CNT_W     = 8;   // half-period counter, CLK_DIV up to 255
  localparam int unsigned BIT_CNT_W = 5;   // counts 0..WORD_W samples
  localparam int unsigned GAP_W     = 9;   // holds 2*CLK_DIV-1 up to 509

  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_NOP   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Command payload as presented on the valid/ready handshake.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] word;
  } cmd_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: half-period counter with rise/fall strobes.
// rise_c/fall_c flag the SYS_CLK cycle whose closing edge toggles sclk.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap_c;

  // Count half periods; disabled or cleared parks the clock low at count 0.
  always_comb begin
    wrap_c = en && (cnt_q == CNT_MAX);
    rise_c = wrap_c && !sclk_q;
    fall_c = wrap_c && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr || !en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap_c) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Counter and clock level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_host.sv
// SPI host: shifts 16-bit command words out MSB-first and returns the MISO word.
// Optional macro SPI_HOST_MISO_SYNC_EN: two-flop MISO synchroniser, sample
// point (and RSP_VALID) moved two SYS_CLK cycles later.
module spi_host
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [WORD_W-1:0] CMD_WORD,
  input  logic              CMD_LAST,
  output logic              RSP_VALID,
  output logic [WORD_W-1:0] RSP_WORD,
  output logic              SPI_CLK,
  output logic              SSEL,
  output logic              MOSI,
  input  logic              MISO
);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      tx_q, tx_d;
  logic [WORD_W-2:0]      rx_q, rx_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   last_q, last_d;
  logic                   first_q, first_d;
  logic                   ssel_q, ssel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]      rsp_word_q, rsp_word_d;
  logic                   rdy_en_q, rdy_en_d;

  cmd_t                   cmd_c;
  logic                   accept_c;
  logic                   done_c;
  logic                   clk_en_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   samp_c;
  logic                   miso_bit_c;

  assign cmd_c     = '{last: CMD_LAST, word: CMD_WORD};
  assign CMD_READY = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept_c  = CMD_VALID && CMD_READY;
  // The would-be 17th rise ends the word; the clock stays low instead.
  assign done_c    = (state_q == ST_SHIFT) && rise_c && (bit_cnt_q == BIT_CNT_W'(WORD_W));
  // Starting the counter on a HOLD accept puts the first rise CLK_DIV cycles later.
  assign clk_en_c  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     ((state_q == ST_HOLD) && accept_c);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (SYS_CLK),
    .rst    (SYS_RST),
    .en     (clk_en_c),
    .clr    (done_c),
    .sclk   (SPI_CLK),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

`ifdef SPI_HOST_MISO_SYNC_EN
  logic [1:0] miso_sync_q, miso_sync_d;
  logic [2:0] fall_dly_q, fall_dly_d;

  // Synchronise MISO and delay the sample strobe to match.
  always_comb begin
    miso_sync_d = {miso_sync_q[0], MISO};
    fall_dly_d  = {fall_dly_q[1:0], fall_c};
  end

  // Synchroniser and strobe delay registers.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      miso_sync_q <= '0;
      fall_dly_q  <= '0;
    end else begin
      miso_sync_q <= miso_sync_d;
      fall_dly_q  <= fall_dly_d;
    end
  end

  assign samp_c     = fall_dly_q[2];
  assign miso_bit_c = miso_sync_q[1];
`else
  logic fall_dly_q, fall_dly_d;

  // Sample in the first cycle SPI_CLK reads low after a falling edge.
  always_comb begin
    fall_dly_d = fall_c;
  end

  // Sample strobe register.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      fall_dly_q <= 1'b0;
    end else begin
      fall_dly_q <= fall_dly_d;
    end
  end

  assign samp_c     = fall_dly_q;
  assign miso_bit_c = MISO;
`endif

  // Next-state, shifters, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_d      = last_q;
    first_d     = first_q;
    rsp_valid_d = 1'b0;
    rsp_word_d  = rsp_word_q;
    rdy_en_d    = 1'b1;

    if (samp_c) begin
      rx_d      = {rx_q[WORD_W-3:0], miso_bit_c};
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
        rsp_valid_d = 1'b1;
        rsp_word_d  = {rx_q, miso_bit_c};
      end
    end

    if (rise_c) begin
      first_d = 1'b0;
      if (!first_q && !done_c) begin
        tx_d = {tx_q[WORD_W-2:0], 1'b0};
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          tx_d      = cmd_c.word;
          last_d    = cmd_c.last;
          first_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (rise_c) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (done_c) begin
          if (last_q) begin
            gap_cnt_d = GAP_W'(2 * CLK_DIV - 1);
            tx_d      = '0;
            state_d   = ST_GAP;
          end else begin
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (accept_c) begin
          tx_d      = cmd_c.word;
          last_d    = cmd_c.last;
          first_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ssel_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b0;
      ssel_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_word_q  <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_q      <= last_d;
      first_q     <= first_d;
      ssel_q      <= ssel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_word_q  <= rsp_word_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign SSEL      = ssel_q;
  assign MOSI      = tx_q[WORD_W-1];
  assign RSP_VALID = rsp_valid_q;
  assign RSP_WORD  = rsp_word_q;

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: SPI slave model plus MOSI/response scoreboards.
`timescale 1ns/1ps
module tb_spi_host;

  localparam int D = 4;
`ifdef SPI_HOST_MISO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_WORD;
  logic        CMD_LAST;
  logic        RSP_VALID;
  logic [15:0] RSP_WORD;
  logic        SPI_CLK;
  logic        SSEL;
  logic        MOSI;
  logic        MISO;

  always #5 SYS_CLK = ~SYS_CLK;

  spi_host #(.CLK_DIV(D)) dut (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WORD  (CMD_WORD),
    .CMD_LAST  (CMD_LAST),
    .RSP_VALID (RSP_VALID),
    .RSP_WORD  (RSP_WORD),
    .SPI_CLK   (SPI_CLK),
    .SSEL      (SSEL),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_mosi_q[$];
  logic [15:0] exp_rsp_q[$];
  logic [15:0] slave_q[$];

  logic        spi_prev  = 1'b0;
  logic        ssel_prev = 1'b1;
  logic [3:0]  ridx      = 4'd0;
  int          fidx      = 0;
  logic [15:0] slv_word  = 16'h0;
  logic [15:0] mosi_sr   = 16'h0;
  int rsp_cnt = 0, rsp_cyc = 0, acc_cyc = 0;
  int ssel_fall_cyc = 0, ssel_rise_cyc = 0, ssel_rise_n = 0;
  int hi_run = 0, last_hi_run = 0, first_rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One SYS_CLK cycle; runs the slave model and monitors at the falling edge.
  task automatic tick();
    logic [15:0] e;
    @(negedge SYS_CLK);
    cyc++;
    if (SSEL) begin
      ridx = 4'd0;
      fidx = 0;
      MISO = 1'b0;
    end else begin
      if (!spi_prev && SPI_CLK) begin
        if (ridx == 4'd0) begin
          slv_word = (slave_q.size() > 0) ? slave_q.pop_front() : 16'h0;
          first_rise_cyc = cyc;
        end
        MISO = slv_word[4'd15 - ridx];
        ridx = ridx + 4'd1;
      end
      if (spi_prev && !SPI_CLK) begin
        mosi_sr = {mosi_sr[14:0], MOSI};
        fidx++;
        if (fidx == 16) begin
          fidx = 0;
          e = 'x;
          if (exp_mosi_q.size() > 0) e = exp_mosi_q.pop_front();
          chk("mosi_frame", 32'(mosi_sr), 32'(e));
        end
      end
    end
    if (RSP_VALID) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      e = 'x;
      if (exp_rsp_q.size() > 0) e = exp_rsp_q.pop_front();
      chk("rsp_word", 32'(RSP_WORD), 32'(e));
    end
    if (!ssel_prev && SSEL) begin
      ssel_rise_cyc = cyc;
      ssel_rise_n++;
    end
    if (ssel_prev && !SSEL) begin
      ssel_fall_cyc = cyc;
      last_hi_run   = hi_run;
    end
    hi_run    = SSEL ? hi_run + 1 : 0;
    spi_prev  = SPI_CLK;
    ssel_prev = SSEL;
  endtask

  // Offer a word until accepted; record accept cycle and push expectations.
  task automatic send(input logic [15:0] w, input logic last, input logic [15:0] sw,
                      input bit expect_it);
    CMD_VALID = 1'b1;
    CMD_WORD  = w;
    CMD_LAST  = last;
    for (int i = 0; i < 3000 && !CMD_READY; i++) tick();
    if (!CMD_READY) begin
      chk("ready_timeout", 32'(CMD_READY), 32'd1);
    end else begin
      acc_cyc = cyc;
      slave_q.push_back(sw);
      if (expect_it) begin
        exp_mosi_q.push_back(w);
        exp_rsp_q.push_back(sw);
      end
    end
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 3000 && rsp_cnt < target; i++) tick();
    if (rsp_cnt < target) chk("rsp_timeout", 32'(rsp_cnt), 32'(target));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && !(SSEL && CMD_READY); i++) tick();
    if (!(SSEL && CMD_READY)) chk("idle_timeout", 32'(CMD_READY), 32'd1);
  endtask

  initial begin
    int a;
    int a2;
    int n0;
    int r0;
    SYS_RST   = 1'b1;
    CMD_VALID = 1'b0;
    CMD_WORD  = 16'h0;
    CMD_LAST  = 1'b0;
    MISO      = 1'b0;

    // Reset state
    tick();
    chk("rst_ssel",  32'(SSEL), 32'd1);
    chk("rst_sclk",  32'(SPI_CLK), 32'd0);
    chk("rst_mosi",  32'(MOSI), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_rspv",  32'(RSP_VALID), 32'd0);
    chk("rst_rspw",  32'(RSP_WORD), 32'd0);
    tick();
    SYS_RST = 1'b0;
    chk("ready_held_low", 32'(CMD_READY), 32'd0);
    tick();
    chk("ready_after_rst", 32'(CMD_READY), 32'd1);

    // Single read word, timing against the accept cycle
    send(16'h8000, 1'b1, 16'h1234, 1'b1);
    a = acc_cyc;
    chk("t1_ssel_fall", 32'(ssel_fall_cyc - a), 32'd1);
    wait_rsp(1);
    chk("t1_first_rise", 32'(first_rise_cyc - a), 32'(1 + D));
    chk("t1_rsp_cycle", 32'(rsp_cyc - a), 32'(2 + 32 * D + SYNC_LAT));
    wait_idle();
    chk("t1_ssel_rise", 32'(ssel_rise_cyc - a), 32'(1 + 33 * D));

    // Three-word burst with SSEL held low
    n0 = ssel_rise_n;
    r0 = rsp_cnt;
    send(16'h8000, 1'b0, 16'hAAAA, 1'b1);
    a = acc_cyc;
    send(16'h0000, 1'b0, 16'h0001, 1'b1);
    a2 = acc_cyc;
    chk("burst_accept_hold", 32'(a2 - a), 32'(1 + 33 * D));
    send(16'h0000, 1'b1, 16'h5555, 1'b1);
    chk("hold_first_rise", 32'(first_rise_cyc - a2), 32'(D));
    wait_rsp(r0 + 3);
    wait_idle();
    chk("burst_ssel_rises", 32'(ssel_rise_n - n0), 32'd1);
    chk("burst_rsp_count", 32'(rsp_cnt - r0), 32'd3);

    // Write address then data with CMD_VALID held through SHIFT
    r0 = rsp_cnt;
    send(16'h4005, 1'b0, 16'h0000, 1'b1);
    a = acc_cyc;
    send(16'hBEEF, 1'b1, 16'h0F0F, 1'b1);
    chk("wr_accept_in_hold", 32'(acc_cyc - a), 32'(1 + 33 * D));
    wait_rsp(r0 + 2);
    wait_idle();

    // Reset in the middle of a word
    r0 = rsp_cnt;
    send(16'hFFFF, 1'b1, 16'h7777, 1'b0);
    for (int i = 0; i < 3000 && fidx < 8; i++) tick();
    if (fidx < 8) chk("mid_rst_wait", 32'(fidx), 32'd8);
    SYS_RST = 1'b1;
    tick();
    chk("mid_rst_ssel", 32'(SSEL), 32'd1);
    chk("mid_rst_sclk", 32'(SPI_CLK), 32'd0);
    chk("mid_rst_mosi", 32'(MOSI), 32'd0);
    chk("mid_rst_ready", 32'(CMD_READY), 32'd0);
    chk("mid_rst_rspw", 32'(RSP_WORD), 32'd0);
    SYS_RST = 1'b0;
    tick();
    chk("mid_rst_ready_back", 32'(CMD_READY), 32'd1);
    for (int i = 0; i < 4 * 33 * D; i++) tick();
    chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'(r0));
    send(16'h8000, 1'b1, 16'h1234, 1'b1);
    wait_rsp(r0 + 1);
    wait_idle();

    // Two separate frames: minimum SSEL-high time between them
    r0 = rsp_cnt;
    send(16'h1111, 1'b1, 16'h2222, 1'b1);
    wait_rsp(r0 + 1);
    send(16'h3333, 1'b1, 16'h4444, 1'b1);
    chk("gap_ssel_high", 32'(last_hi_run >= 2 * D), 32'd1);
    wait_rsp(r0 + 2);
    wait_idle();

    for (int i = 0; i < 10; i++) tick();
    chk("mosi_q_empty", 32'(exp_mosi_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_host.md
# spi_host

SPI master for the host end of the FPGA register-file link: serialises 16-bit command words MSB-first onto SPI_CLK/MOSI and collects the 16-bit MISO word clocked back on the same transfer. The register slave sits on the far end. This block lets on-board logic or a test harness drive the link from the same SYS_CLK domain:
- read: 0b10 in [15:14], then sequential reads;
- write: 0b01 in [15:14], address in [9:0].

Command words arrive over a valid/ready handshake. Response words leave as single-cycle strobes.

## Interface
- CLK_DIV, 4: SPI half-period in SYS_CLK cycles; legal range 4..255.
- SYS_CLK  in  1  system clock; all logic on its rising edge.
- SYS_RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  CMD_WORD/CMD_LAST valid.
- CMD_READY  out  1  block accepts a command this cycle.
- CMD_WORD  in  16  word to shift out, bit 15 first.
- CMD_LAST  in  1  release SSEL after this word.
- RSP_VALID  out  1  one-cycle strobe: RSP_WORD valid.
- RSP_WORD  out  16  word sampled from MISO during the last transfer.
- SPI_CLK  out  1  serial clock, idle low.
- SSEL  out  1  slave select, active low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

## Operation
- States:
  - IDLE: CMD_READY=1, SSEL=1.
  - SETUP: SSEL=0, MOSI=bit15, SPI_CLK=0, for CLK_DIV cycles.
  - SHIFT: 16 SPI_CLK periods.
  - HOLD: SSEL=0, SPI_CLK=0, CMD_READY=1.
  - GAP: SSEL=1 for 2*CLK_DIV cycles.
- Handshake is accepted when CMD_VALID && CMD_READY. The word is latched into the tx shifter and CMD_LAST into a flag.
- Transitions on a handshake:
  - IDLE -> SETUP.
  - HOLD -> SHIFT (no SETUP; MOSI = new bit15 on the accept cycle).
- End of SHIFT:
  - last flag = 1 -> GAP.
  - last flag = 0 -> HOLD.
- GAP -> IDLE when its count expires.
- HOLD waits indefinitely with SSEL low. CMD_VALID is ignored while CMD_READY=0.
- SHIFT edge behaviour:
  - SPI_CLK toggles every CLK_DIV cycles.
  - Each rising edge except the first shifts MOSI to the next bit. MOSI is therefore stable for CLK_DIV cycles on both sides of every falling edge.
  - MISO is sampled into the rx shifter on each falling edge, MSB first.
- After the 16th falling edge, SPI_CLK stays low for CLK_DIV further cycles before the SHIFT exit.
- Response: RSP_VALID pulses for one cycle, the cycle after the 16th sample. RSP_WORD holds its value until the next strobe. There is no backpressure.
- Reset, at any time including mid-word:
  - next cycle: SSEL=1, SPI_CLK=0, MOSI=0, CMD_READY=0, RSP_VALID=0, RSP_WORD=0, state IDLE.
  - CMD_READY rises the cycle after SYS_RST deasserts.
  - A partial word is discarded; no RSP_VALID is produced.

## Timing
- Single word from IDLE: handshake at cycle 0 -> SSEL falls at cycle 1.
  - First SPI_CLK rise at 1+CLK_DIV.
  - 16th fall at 1+32*CLK_DIV.
  - RSP_VALID at 2+32*CLK_DIV.
  - SSEL rises at 1+33*CLK_DIV.
- Back-to-back word from HOLD: first rise CLK_DIV cycles after the accept. There is no SSEL gap between words.
- Minimum SSEL-high time between frames: 2*CLK_DIV cycles.
- CMD_READY is combinational from state only, not from CMD_VALID.

## Configuration
- SPI_HOST_MISO_SYNC_EN defined:
  - MISO passes through a two-flop synchroniser.
  - The sample point is the second SYS_CLK after each falling edge.
  - RSP_VALID moves 2 cycles later.
- SPI_HOST_MISO_SYNC_EN undefined: MISO is sampled directly on the falling-edge cycle. Use only when the slave shares SYS_CLK.

## Structure
- Shared package spi_pkg:
  - state enum;
  - WORD_W=16, ADDR_W=10;
  - CMD_READ=2'b10, CMD_WRITE=2'b01, CMD_NOP=2'b00.
- Sub-module spi_clk_gen:
  - half-period counter;
  - outputs SPI_CLK level plus rise/fall strobes;
  - enable and synchronous reset.
- Top holds the FSM, shifters, bit counter and gap counter.

## Test plan
- CLK_DIV=4, single word 0x8000 with CMD_LAST=1, slave model returns 0x1234:
  - MOSI frame = 0x8000;
  - RSP_WORD=0x1234 at cycle 130;
  - SSEL high again at cycle 133.
- Burst of 0x8000, 0x0000, 0x0000 (last on the third), slave returns 0xAAAA, 0x0001, 0x5555:
  - SSEL stays low across all three words;
  - three RSP_VALID strobes, in that order.
- Write 0x4005 then data 0xBEEF, with CMD_VALID held high during SHIFT:
  - no second accept until HOLD;
  - MOSI frames exactly 0x4005 then 0xBEEF.
- SYS_RST asserted after bit 7 of 0xFFFF:
  - next cycle SSEL=1, SPI_CLK=0, MOSI=0;
  - no RSP_VALID;
  - a new 0x8000 transfers cleanly after release.
- Two frames with CMD_LAST=1 each: SSEL high for ≥8 cycles between them at CLK_DIV=4.
- With SPI_HOST_MISO_SYNC_EN, MISO toggling at the rising edges: RSP_WORD matches the slave word, and RSP_VALID is 2 cycles later than the unsynchronised build.
